// File: rtl/adc_capture_ctrl.sv
// ADC capture run controller: IDLE -> CLEAR(2) -> ARMED -> HALT(2) -> IDLE, all outputs registered, monitor tap only (no tready).
// Optional idle-timeout logic is compiled in with `define ADC_CAPTURE_TIMEOUT_EN.
module adc_capture_ctrl (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cfg_start,
  input  logic        cfg_abort,
  input  logic [15:0] cfg_trigger_level,
  input  logic [7:0]  cfg_limiter,
  input  logic [15:0] cfg_packets,
  input  logic [31:0] cfg_timeout,
  input  logic        s_axis_tvalid,
  input  logic [31:0] s_axis_tdata,
  output logic [15:0] trigger_level,
  output logic [7:0]  limiter,
  output logic        reset_trigger,
  output logic        reset_max_sum,
  output logic        busy,
  output logic        done,
  output logic        timed_out,
  output logic        aborted,
  output logic [15:0] packets_done,
  output logic [31:0] words_seen,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_ARMED = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_phase;
  logic [15:0] r_packets;
  logic [15:0] r_trigger_level;
  logic [7:0]  r_limiter;
  logic        r_reset_trigger;
  logic        r_reset_max_sum;
  logic        r_busy;
  logic        r_done;
  logic        r_aborted;
  logic [15:0] r_packets_done;
  logic [31:0] r_words_seen;

  logic        w_start;
  logic        w_pkt_end;
  logic [15:0] w_pd_nxt;
  logic        w_complete;
  logic        w_tmo;

  assign w_start    = (r_state == S_IDLE) && cfg_start && !cfg_abort;
  assign w_pkt_end  = s_axis_tvalid && (s_axis_tdata[31:30] == 2'b10);
  assign w_pd_nxt   = (w_pkt_end && (r_packets_done != 16'hFFFF)) ? r_packets_done + 16'd1 : r_packets_done;
  assign w_complete = w_pkt_end && (r_packets != 16'd0) && (w_pd_nxt == r_packets);

`ifdef ADC_CAPTURE_TIMEOUT_EN
  logic [31:0] r_timeout;
  logic [31:0] r_idle;
  logic        r_timed_out;
  logic [31:0] w_idle_nxt;
  logic        w_unused;

  assign w_unused   = ^s_axis_tdata[29:0];
  assign w_idle_nxt = s_axis_tvalid ? 32'd0 : r_idle + 32'd1;
  // A beat is never idle, so a timeout cannot coincide with a packet end here.
  assign w_tmo      = (r_timeout != 32'd0) && !s_axis_tvalid && (w_idle_nxt == r_timeout);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_timeout   <= '0;
      r_idle      <= '0;
      r_timed_out <= 1'b0;
    end else begin
      r_idle <= (r_state == S_ARMED) ? w_idle_nxt : 32'd0;
      if (w_start) begin
        r_timeout   <= cfg_timeout;
        r_timed_out <= 1'b0;
      end else if ((r_state == S_ARMED) && !cfg_abort && !w_complete && w_tmo) begin
        r_timed_out <= 1'b1;
      end
    end
  end

  assign timed_out = r_timed_out;
`else
  logic w_unused;

  assign w_unused  = ^{cfg_timeout, s_axis_tdata[29:0]};
  assign w_tmo     = 1'b0;
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state         <= S_IDLE;
      r_phase         <= 1'b0;
      r_packets       <= '0;
      r_trigger_level <= '0;
      r_limiter       <= '0;
      r_reset_trigger <= 1'b0;
      r_reset_max_sum <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_aborted       <= 1'b0;
      r_packets_done  <= '0;
      r_words_seen    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state         <= S_CLEAR;
            r_phase         <= 1'b0;
            r_packets       <= cfg_packets;
            r_trigger_level <= cfg_trigger_level;
            r_limiter       <= cfg_limiter;
            r_reset_max_sum <= 1'b1;
            r_busy          <= 1'b1;
            r_done          <= 1'b0;
            r_aborted       <= 1'b0;
            r_packets_done  <= '0;
            r_words_seen    <= '0;
          end
        end
        S_CLEAR: begin
          if (cfg_abort) begin
            r_state         <= S_HALT;
            r_phase         <= 1'b0;
            r_reset_max_sum <= 1'b0;
            r_aborted       <= 1'b1;
          end else if (r_phase) begin
            r_state         <= S_ARMED;
            r_reset_max_sum <= 1'b0;
            r_reset_trigger <= 1'b1;
          end else begin
            r_phase <= 1'b1;
          end
        end
        S_ARMED: begin
          if (s_axis_tvalid) r_words_seen <= r_words_seen + 32'd1;
          r_packets_done <= w_pd_nxt;
          // Abort leaves done alone; completion outranks timeout.
          if (cfg_abort) begin
            r_state         <= S_HALT;
            r_phase         <= 1'b0;
            r_reset_trigger <= 1'b0;
            r_aborted       <= 1'b1;
          end else if (w_complete || w_tmo) begin
            r_state         <= S_HALT;
            r_phase         <= 1'b0;
            r_reset_trigger <= 1'b0;
            r_done          <= 1'b1;
          end
        end
        S_HALT: begin
          if (r_phase) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_phase <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign state         = r_state;
  assign trigger_level = r_trigger_level;
  assign limiter       = r_limiter;
  assign reset_trigger = r_reset_trigger;
  assign reset_max_sum = r_reset_max_sum;
  assign busy          = r_busy;
  assign done          = r_done;
  assign aborted       = r_aborted;
  assign packets_done  = r_packets_done;
  assign words_seen    = r_words_seen;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl; end-of-run status is checked against a queue of expected results.
module tb_adc_capture_ctrl;

  logic        aclk;
  logic        aresetn;
  logic        cfg_start;
  logic        cfg_abort;
  logic [15:0] cfg_trigger_level;
  logic [7:0]  cfg_limiter;
  logic [15:0] cfg_packets;
  logic [31:0] cfg_timeout;
  logic        s_axis_tvalid;
  logic [31:0] s_axis_tdata;
  logic [15:0] trigger_level;
  logic [7:0]  limiter;
  logic        reset_trigger;
  logic        reset_max_sum;
  logic        busy;
  logic        done;
  logic        timed_out;
  logic        aborted;
  logic [15:0] packets_done;
  logic [31:0] words_seen;
  logic [1:0]  state;

  typedef struct {
    logic [15:0] pd;
    logic [31:0] ws;
    logic        dn;
    logic        to;
    logic        ab;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  adc_capture_ctrl dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_trigger_level(cfg_trigger_level), .cfg_limiter(cfg_limiter),
    .cfg_packets(cfg_packets), .cfg_timeout(cfg_timeout),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .trigger_level(trigger_level), .limiter(limiter),
    .reset_trigger(reset_trigger), .reset_max_sum(reset_max_sum),
    .busy(busy), .done(done), .timed_out(timed_out), .aborted(aborted),
    .packets_done(packets_done), .words_seen(words_seen), .state(state)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {24'd0, state, busy, done, timed_out, aborted, reset_trigger, reset_max_sum}, 32'd0);
    chk({tag, "_cfg"}, {8'd0, trigger_level, limiter}, 32'd0);
    chk({tag, "_pd"}, {16'd0, packets_done}, 32'd0);
    chk({tag, "_ws"}, words_seen, 32'd0);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = q.pop_front();
      chk({tag, "_pd"}, {16'd0, packets_done}, {16'd0, e.pd});
      chk({tag, "_ws"}, words_seen, e.ws);
      chk({tag, "_st"}, {29'd0, done, timed_out, aborted}, {29'd0, e.dn, e.to, e.ab});
    end
  endtask

  task automatic wait_state(input string tag, input logic [1:0] s, input int budget);
    int n = 0;
    while (state !== s && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {30'd0, state}, {30'd0, s});
  endtask

  task automatic beat(input logic [31:0] d);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 32'd0;
  endtask

  task automatic start_run(input logic [15:0] pk, input logic [15:0] lvl, input logic [7:0] lim, input logic [31:0] tmo);
    cfg_packets       = pk;
    cfg_trigger_level = lvl;
    cfg_limiter       = lim;
    cfg_timeout       = tmo;
    cfg_start         = 1'b1;
    tick();
    cfg_start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    aresetn = 1'b0;
    cfg_start = 1'b0; cfg_abort = 1'b0;
    cfg_trigger_level = 16'd0; cfg_limiter = 8'd0; cfg_packets = 16'd0; cfg_timeout = 32'd0;
    s_axis_tvalid = 1'b0; s_axis_tdata = 32'd0;
    tick();
    tick();
    chk_zero("reset");
    aresetn = 1'b1;

    // Three-packet run with full CLEAR/HALT sequencing.
    cfg_packets = 16'd3; cfg_trigger_level = 16'h0100; cfg_limiter = 8'd5; cfg_timeout = 32'd0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("clr1_state", {30'd0, state}, 32'd1);
    chk("clr1_flags", {29'd0, reset_max_sum, reset_trigger, busy}, 32'b101);
    chk("clr1_cfg", {8'd0, trigger_level, limiter}, {8'd0, 16'h0100, 8'd5});
    tick();
    chk("clr2_state", {30'd0, state, reset_max_sum}, 32'b011);
    tick();
    chk("armed_state", {29'd0, state, reset_max_sum}, 32'b100);
    chk("armed_rtrig", {31'd0, reset_trigger}, 32'd1);
    q.push_back('{16'd3, 32'd9, 1'b1, 1'b0, 1'b0});
    cfg_start = 1'b1; cfg_trigger_level = 16'h1234;
    tick();
    cfg_start = 1'b0;
    chk("busy_start_ign", {14'd0, state, trigger_level}, {14'd0, 2'd2, 16'h0100});
    for (int p = 0; p < 3; p++) begin
      beat(32'h0000_0001);
      beat(32'h4000_0002);
      beat(32'h8000_0003);
      if (p == 1) chk("pkt_mid", {16'd0, packets_done, state}, {16'd0, 16'd2, 2'd2} >> 0);
    end
    chk("halt_entry", {29'd0, state, reset_trigger}, 32'b110);
    sb_check("run3pkt");
    tick();
    chk("halt2_state", {30'd0, state, busy}, 32'b111);
    tick();
    chk("idle_after", {30'd0, state, busy}, 32'b000);

    // Free run ending on silence (or staying armed without the timeout build).
    start_run(16'd0, 16'h0200, 8'd7, 32'd100);
    chk("start_clears", {30'd0, done, state}, 32'b010);
`ifdef ADC_CAPTURE_TIMEOUT_EN
    q.push_back('{16'd0, 32'd10, 1'b1, 1'b1, 1'b0});
`else
    q.push_back('{16'd0, 32'd10, 1'b0, 1'b0, 1'b1});
`endif
    for (int i = 0; i < 10; i++) beat(32'h10 + i);
    repeat (99) tick();
    chk("tmo_99", {30'd0, state}, 32'd2);
    tick();
`ifdef ADC_CAPTURE_TIMEOUT_EN
    chk("tmo_100", {29'd0, state, timed_out}, 32'b111);
    sb_check("timeout");
`else
    chk("tmo_off_100", {29'd0, state, timed_out}, 32'b100);
    repeat (20) tick();
    chk("tmo_off_120", {30'd0, state}, 32'd2);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    sb_check("notimeout");
`endif
    wait_state("wait_idle2", 2'd0, 10);

    // Abort on the same cycle as a packet end.
    start_run(16'd0, 16'h0300, 8'd1, 32'd0);
    q.push_back('{16'd1, 32'd4, 1'b0, 1'b0, 1'b1});
    beat(32'h0000_0001);
    beat(32'h0000_0002);
    beat(32'h0000_0003);
    cfg_abort = 1'b1;
    beat(32'h8000_0004);
    cfg_abort = 1'b0;
    chk("abort_halt", {29'd0, state, reset_trigger}, 32'b110);
    sb_check("abort");
    wait_state("wait_idle3", 2'd0, 10);

    // Packet completion on the fifth cycle after arming with timeout=5.
    start_run(16'd1, 16'h0400, 8'd2, 32'd5);
    q.push_back('{16'd1, 32'd1, 1'b1, 1'b0, 1'b0});
    repeat (4) tick();
    chk("prio_pre", {30'd0, state}, 32'd2);
    beat(32'h8000_0000);
    chk("prio_halt", {30'd0, state}, 32'd3);
    sb_check("prio");
    wait_state("wait_idle4", 2'd0, 10);

    cfg_start = 1'b1; cfg_abort = 1'b1;
    tick();
    cfg_start = 1'b0; cfg_abort = 1'b0;
    chk("startabort_ign", {28'd0, state, busy, done, aborted}, 32'b00010);

    // Asynchronous reset in the middle of a run.
    start_run(16'd5, 16'h0500, 8'd3, 32'd0);
    beat(32'h8000_0000);
    tick();
    beat(32'h8000_0000);
    chk("pre_rst", {14'd0, state, packets_done}, {14'd0, 2'd2, 16'd2});
    aresetn = 1'b0;
    #1;
    chk_zero("async_rst");
    tick();
    aresetn = 1'b1;
    cfg_packets = 16'd0; cfg_timeout = 32'd0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("first_start", {30'd0, state}, 32'd1);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    chk("clear_abort", {29'd0, state, aborted}, 32'b111);
    wait_state("wait_idle5", 2'd0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
